// File: rtl/ifetch_pkg.sv
// Shared fetch-side definitions: default queue depth and width helpers
// used by the fetch unit and its entry queue.
package ifetch_pkg;

    // Default number of queue entries / outstanding instruction memory requests.
    localparam int IFETCH_DEPTH_DEFAULT = 4;

    // Instruction word and address width used throughout the fetch path.
    typedef logic [31:0] word_t;

    // Counter width: must hold the value DEPTH itself (0..DEPTH).
    function automatic int ifetch_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Pointer width: indexes 0..DEPTH-1, wraps naturally for power-of-two depth.
    function automatic int ifetch_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bundle: PC/redirect inputs, instruction memory request and
// response channels, and the decode-facing instruction output.
interface ifetch_if;
    import ifetch_pkg::*;

    word_t PC;
    logic  flush;
    logic  fetch_stall;

    logic  imem_req_valid;
    word_t imem_req_addr;
    logic  imem_req_ready;

    logic  imem_resp_valid;
    word_t imem_resp_data;

    logic  IF_valid;
    word_t IF_instr;
    word_t IF_pc;
    logic  IF_ready;

    // The fetch unit itself.
    modport master (
        input  PC, flush, imem_req_ready, imem_resp_valid, imem_resp_data, IF_ready,
        output fetch_stall, imem_req_valid, imem_req_addr, IF_valid, IF_instr, IF_pc
    );

    // The surroundings: PC register, instruction memory and decode.
    modport slave (
        output PC, flush, imem_req_ready, imem_resp_valid, imem_resp_data, IF_ready,
        input  fetch_stall, imem_req_valid, imem_req_addr, IF_valid, IF_instr, IF_pc
    );
endinterface

// File: rtl/ifetch_entry_queue.sv
// Circular fetch queue: an entry is allocated at the tail when a request
// fires, filled in order through a separate fill pointer as responses
// arrive, and freed at the head when decode takes it.
module ifetch_entry_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH = IFETCH_DEPTH_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clear,
    input  logic  alloc,
    input  word_t alloc_pc,
    input  logic  fill,
    input  word_t fill_data,
    input  logic  pop,
    output logic  head_filled,
    output word_t head_pc,
    output word_t head_instr
);
    localparam int PW = ifetch_ptr_w(DEPTH);

    // Payload storage carries no reset; validity lives in filled_reg.
    word_t pc_mem    [DEPTH];
    word_t instr_mem [DEPTH];
    logic  filled_reg [DEPTH];

    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [PW-1:0] fill_reg;

    // Head, tail and fill pointers; a redirect rewinds them all to zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head_reg <= '0;
            tail_reg <= '0;
            fill_reg <= '0;
        end else begin
            if (alloc) tail_reg <= tail_reg + 1'b1;
            if (fill)  fill_reg <= fill_reg + 1'b1;
            if (pop)   head_reg <= head_reg + 1'b1;
        end
    end

    // Payload writes: PC at allocation, instruction word at fill.
    always_ff @(posedge clk) begin
        if (alloc) pc_mem[tail_reg]    <= alloc_pc;
        if (fill)  instr_mem[fill_reg] <= fill_data;
    end

    // Per-entry filled flag; fill and alloc/pop never target the same slot
    // in one cycle because the fill slot is always allocated and unfilled.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_filled
            // Set on fill, cleared on allocation, pop or redirect.
            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    filled_reg[gi] <= 1'b0;
                end else if (fill && (fill_reg == PW'(gi))) begin
                    filled_reg[gi] <= 1'b1;
                end else if ((alloc && (tail_reg == PW'(gi))) ||
                             (pop && (head_reg == PW'(gi)))) begin
                    filled_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Head is read combinationally so decode sees it in the same cycle;
    // the filled flag is registered, so a response is never bypassed.
    assign head_filled = filled_reg[head_reg];
    assign head_pc     = pc_mem[head_reg];
    assign head_instr  = instr_mem[head_reg];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues PC-addressed requests to instruction
// memory, buffers in-order responses in a small queue and hands them to
// decode. Responses belonging to requests issued before a redirect are
// counted in drop and discarded as they come back.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int DEPTH = IFETCH_DEPTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    ifetch_if.master bus
);
    localparam int CW = ifetch_cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] unfilled_reg, unfilled_next;
    logic [CW-1:0] drop_reg, drop_next;
    logic [CW:0]   credit_sum;

    logic  req_valid;
    logic  fire;
    logic  resp_drop;
    logic  resp_fill;
    logic  if_valid;
    logic  pop;
    logic  head_filled;
    word_t head_pc;
    word_t head_instr;

    // Responses still owed by memory (stale + live) must never exceed DEPTH,
    // otherwise drop could overflow across back-to-back redirects.
    assign credit_sum = {1'b0, drop_reg} + {1'b0, unfilled_reg};

    assign req_valid = !rst && !bus.flush && (count_reg < DEPTH_C) &&
                       (credit_sum < {1'b0, DEPTH_C});
    assign fire      = req_valid && bus.imem_req_ready;

    // Stale responses are consumed first; a response with nothing owed is ignored.
    assign resp_drop = bus.imem_resp_valid && (drop_reg != '0);
    assign resp_fill = bus.imem_resp_valid && (drop_reg == '0) &&
                       (unfilled_reg != '0) && !bus.flush;

    assign if_valid  = head_filled && (count_reg != '0) && !bus.flush && !rst;
    assign pop       = if_valid && bus.IF_ready;

    assign bus.fetch_stall    = !fire;
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = bus.PC;
    assign bus.IF_valid       = if_valid;
    assign bus.IF_instr       = head_instr;
    assign bus.IF_pc          = head_pc;

    // Counter next-state: a redirect turns every unfilled entry into a stale
    // response (less the one arriving right now); otherwise net effect of
    // fire, fill, drop and pop.
    always_comb begin
        count_next    = count_reg;
        unfilled_next = unfilled_reg;
        drop_next     = drop_reg;
        if (bus.flush) begin
            count_next    = '0;
            unfilled_next = '0;
            if (bus.imem_resp_valid && (credit_sum != '0)) begin
                drop_next = CW'(credit_sum - 1'b1);
            end else begin
                drop_next = CW'(credit_sum);
            end
        end else begin
            count_next    = count_reg + CW'(fire) - CW'(pop);
            unfilled_next = unfilled_reg + CW'(fire) - CW'(resp_fill);
            drop_next     = drop_reg - CW'(resp_drop);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg    <= '0;
            unfilled_reg <= '0;
            drop_reg     <= '0;
        end else begin
            count_reg    <= count_next;
            unfilled_reg <= unfilled_next;
            drop_reg     <= drop_next;
        end
    end

    ifetch_entry_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .rst         (rst),
        .clear       (bus.flush),
        .alloc       (fire),
        .alloc_pc    (bus.PC),
        .fill        (resp_fill),
        .fill_data   (bus.imem_resp_data),
        .pop         (pop),
        .head_filled (head_filled),
        .head_pc     (head_pc),
        .head_instr  (head_instr)
    );

endmodule
